hack_mem_map: RTL and testbench

Parametrised data-memory subsystem for the HACK CPU, replacing the fixed single-RAM hookup in the current top level. It decodes the CPU's 15-bit data address into RAM, screen memory and a keyboard register. The keyboard register is backed by a small FIFO with a valid/ready input. A registered second read port on screen memory serves video scan-out. The block sits between `CPU` (`addressM`/`outM`/`writeM`/`inM`) and the board-level I/O.

---
 rtl/hack_mem_map.sv | 131 +++++++++++++
 tb/tb_hack_mem_map.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_mem_map.sv
// HACK data-memory map: RAM, screen (with registered scan-out port) and a FIFO-backed keyboard register.
// inM is combinational; scan_data has 1-cycle latency; key_ready drops when the keyboard FIFO is full.

module hack_kbd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  output logic                     push_rdy,
  input  logic                     pop,
  output logic [W-1:0]             head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign push_rdy = (count != (PW+1)'(DEPTH));
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop && (count != '0);
  assign head_dat = (count == '0) ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= push_dat;
        wp      <= wp + PW'(1);
      end
      if (do_pop) rp <= rp + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

module hack_mem_map #(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_BASE  = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_ADDR     = 24576,
  parameter int KBD_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [14:0]                     addressM,
  input  logic [15:0]                     outM,
  input  logic                            writeM,
  output logic [15:0]                     inM,
  input  logic [15:0]                     key_data,
  input  logic                            key_valid,
  output logic                            key_ready,
  output logic [$clog2(KBD_DEPTH):0]      kbd_count,
  input  logic [$clog2(SCREEN_WORDS)-1:0] scan_addr,
  output logic [15:0]                     scan_data,
  output logic                            bad_access
);
  localparam int RAW = $clog2(RAM_WORDS);
  localparam int SAW = $clog2(SCREEN_WORDS);

  logic [15:0]    ram    [RAM_WORDS];
  logic [15:0]    screen [SCREEN_WORDS];
  logic [31:0]    addr_ext;
  logic           is_ram;
  logic           is_scr;
  logic           is_kbd;
  logic           is_unmapped;
  logic [RAW-1:0] ram_idx;
  logic [SAW-1:0] scr_idx;
  logic [15:0]    kbd_head;
  logic           kbd_pop;

  assign addr_ext    = {17'd0, addressM};
  assign is_ram      = addr_ext < 32'(RAM_WORDS);
  assign is_scr      = (addr_ext >= 32'(SCREEN_BASE)) && (addr_ext < 32'(SCREEN_BASE + SCREEN_WORDS));
  assign is_kbd      = addr_ext == 32'(KBD_ADDR);
  assign is_unmapped = !(is_ram || is_scr || is_kbd);
  assign ram_idx     = addressM[RAW-1:0];
  assign scr_idx     = SAW'(addr_ext - 32'(SCREEN_BASE));
  // A CPU write to the keyboard address is the acknowledge: it pops the head key.
  assign kbd_pop     = writeM && is_kbd;

  hack_kbd_fifo #(.W(16), .DEPTH(KBD_DEPTH)) u_kbd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (key_valid),
    .push_dat (key_data),
    .push_rdy (key_ready),
    .pop      (kbd_pop),
    .head_dat (kbd_head),
    .count    (kbd_count)
  );

  always_ff @(posedge clk) begin
    if (!reset && writeM) begin
      if (is_ram) ram[ram_idx]    <= outM;
      if (is_scr) screen[scr_idx] <= outM;
    end
  end

  // Non-blocking read of the old word gives read-before-write against a same-cycle CPU write.
  always_ff @(posedge clk) begin
    if (reset) scan_data <= '0;
    else       scan_data <= screen[scan_addr];
  end

  always_ff @(posedge clk) begin
    if (reset)            bad_access <= 1'b0;
    else if (is_unmapped) bad_access <= 1'b1;
  end

  always_comb begin
    inM = '0;
    if (is_ram)      inM = ram[ram_idx];
    else if (is_scr) inM = screen[scr_idx];
    else if (is_kbd) inM = kbd_head;
  end
endmodule

// File: tb/tb_hack_mem_map.sv
// Bench for hack_mem_map: directed vector table, hand-written corner sequences, then random traffic vs a queue/array model.
module tb_hack_mem_map;
  localparam int RAM_WORDS    = 16384;
  localparam int SCREEN_BASE  = 16384;
  localparam int SCREEN_WORDS = 8192;
  localparam int KBD_ADDR     = 24576;
  localparam int KBD_DEPTH    = 4;
  localparam int CW = $clog2(KBD_DEPTH) + 1;
  localparam int SW = $clog2(SCREEN_WORDS);
  localparam int K  = KBD_ADDR;

  logic          clk = 1'b0;
  logic          reset;
  logic [14:0]   addressM;
  logic [15:0]   outM;
  logic          writeM;
  logic [15:0]   inM;
  logic [15:0]   key_data;
  logic          key_valid;
  logic          key_ready;
  logic [CW-1:0] kbd_count;
  logic [SW-1:0] scan_addr;
  logic [15:0]   scan_data;
  logic          bad_access;

  always #5 clk = ~clk;

  hack_mem_map #(
    .RAM_WORDS(RAM_WORDS), .SCREEN_BASE(SCREEN_BASE), .SCREEN_WORDS(SCREEN_WORDS),
    .KBD_ADDR(KBD_ADDR), .KBD_DEPTH(KBD_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM), .inM(inM),
    .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready), .kbd_count(kbd_count),
    .scan_addr(scan_addr), .scan_data(scan_data), .bad_access(bad_access)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: sparse memories of known words, a key queue, a sticky flag.
  logic [15:0] ram_m [int];
  logic [15:0] scr_m [int];
  logic [15:0] kq [$];
  bit          bad_m;
  logic [15:0] scan_m;
  bit          scan_k;

  function automatic int region(input int a);
    if (a < RAM_WORDS) return 0;
    if (a >= SCREEN_BASE && a < SCREEN_BASE + SCREEN_WORDS) return 1;
    if (a == KBD_ADDR) return 2;
    return 3;
  endfunction

  function automatic bit model_read(input int a, output logic [15:0] v);
    v = 16'h0;
    case (region(a))
      0: if (ram_m.exists(a)) begin v = ram_m[a]; return 1; end else return 0;
      1: if (scr_m.exists(a - SCREEN_BASE)) begin v = scr_m[a - SCREEN_BASE]; return 1; end else return 0;
      2: begin if (kq.size() > 0) v = kq[0]; return 1; end
      default: return 1;
    endcase
  endfunction

  task automatic model_edge();
    int a;
    int r;
    bit can_push;
    if (reset) begin
      kq.delete();
      bad_m  = 0;
      scan_m = 16'h0;
      scan_k = 1;
    end else begin
      a = int'(addressM);
      r = region(a);
      can_push = kq.size() < KBD_DEPTH;
      scan_k = scr_m.exists(int'(scan_addr));
      if (scan_k) scan_m = scr_m[int'(scan_addr)];
      if (r == 3) bad_m = 1;
      if (writeM) begin
        if (r == 0) ram_m[a] = outM;
        else if (r == 1) scr_m[a - SCREEN_BASE] = outM;
        else if (r == 2 && kq.size() > 0) void'(kq.pop_front());
      end
      if (key_valid && can_push) kq.push_back(key_data);
    end
  endtask

  task automatic drive(input bit rst, input int addr, input logic [15:0] wdat, input bit wr,
                       input logic [15:0] key, input bit kvld, input int saddr);
    reset     = rst;
    addressM  = 15'(addr);
    outM      = wdat;
    writeM    = wr;
    key_data  = key;
    key_valid = kvld;
    scan_addr = SW'(saddr);
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ei/es = -1 means "not checked" for inM (before the edge) and scan_data (after the edge).
  typedef struct packed {
    bit          rst;
    int          addr;
    logic [15:0] wdat;
    bit          wr;
    logic [15:0] key;
    bit          kvld;
    int          saddr;
    int          ei;
    int          ecnt;
    bit          ebad;
    int          es;
  } vec_t;

  vec_t tbl [$];

  initial begin
    vec_t v;
    logic [15:0] mv;
    int a;
    int sa;

    tbl = '{
      '{1, 0, 16'h0, 0, 16'h0, 0, 0, -1, 0, 0, 0},
      '{0, K, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, -1},
      '{0, 5, 16'h1234, 1, 16'h0, 0, 0, -1, 0, 0, -1},
      '{0, SCREEN_BASE+3, 16'hBEEF, 1, 16'h0, 0, 3, -1, 0, 0, -1},
      '{0, 5, 16'h0, 0, 16'h0, 0, 3, 'h1234, 0, 0, 'hBEEF},
      '{0, SCREEN_BASE+3, 16'h0, 0, 16'h0, 0, 3, 'hBEEF, 0, 0, 'hBEEF},
      '{0, RAM_WORDS-1, 16'h1111, 1, 16'h0, 0, 0, -1, 0, 0, -1},
      '{0, SCREEN_BASE+SCREEN_WORDS-1, 16'h2222, 1, 16'h0, 0, SCREEN_WORDS-1, -1, 0, 0, -1},
      '{0, RAM_WORDS-1, 16'h0, 0, 16'h0, 0, SCREEN_WORDS-1, 'h1111, 0, 0, 'h2222},
      '{0, SCREEN_BASE+SCREEN_WORDS-1, 16'h0, 0, 16'h0, 0, 0, 'h2222, 0, 0, -1},
      '{0, 5, 16'h0, 0, 16'h41, 1, 0, -1, 1, 0, -1},
      '{0, 5, 16'h0, 0, 16'h42, 1, 0, -1, 2, 0, -1},
      '{0, 5, 16'h0, 0, 16'h43, 1, 0, -1, 3, 0, -1},
      '{0, K, 16'h0, 0, 16'h0, 0, 0, 'h41, 3, 0, -1},
      '{0, K, 16'h0, 1, 16'h0, 0, 0, 'h41, 2, 0, -1},
      '{0, K, 16'h0, 1, 16'h0, 0, 0, 'h42, 1, 0, -1},
      '{0, K, 16'h0, 1, 16'h0, 0, 0, 'h43, 0, 0, -1},
      '{0, K, 16'h0, 1, 16'h0, 0, 0, 0, 0, 0, -1},
      '{0, 5, 16'h0, 0, 16'hA0, 1, 0, -1, 1, 0, -1},
      '{0, 5, 16'h0, 0, 16'hA1, 1, 0, -1, 2, 0, -1},
      '{0, 5, 16'h0, 0, 16'hA2, 1, 0, -1, 3, 0, -1},
      '{0, 5, 16'h0, 0, 16'hA3, 1, 0, -1, 4, 0, -1},
      '{0, 5, 16'h0, 0, 16'hA4, 1, 0, -1, 4, 0, -1},
      '{0, K, 16'h0, 0, 16'h0, 0, 0, 'hA0, 4, 0, -1},
      '{0, K, 16'h0, 1, 16'hA5, 1, 0, 'hA0, 3, 0, -1},
      '{0, K, 16'h0, 1, 16'h0, 0, 0, 'hA1, 2, 0, -1},
      '{0, K, 16'h0, 1, 16'hB0, 1, 0, 'hA2, 2, 0, -1},
      '{0, K, 16'h0, 1, 16'h0, 0, 0, 'hA3, 1, 0, -1},
      '{0, K, 16'h0, 1, 16'h0, 0, 0, 'hB0, 0, 0, -1},
      '{0, K, 16'h0, 0, 16'h0, 0, 0, 0, 0, 0, -1},
      '{0, 8193, 16'h0, 1, 16'h0, 0, 0, -1, 0, 0, -1},
      '{0, SCREEN_BASE+1, 16'h0, 1, 16'h0, 0, 0, -1, 0, 0, -1},
      '{0, K+1, 16'h0, 0, 16'h0, 0, 0, 0, 0, 1, -1},
      '{0, 5, 16'h0, 0, 16'h0, 0, 0, 'h1234, 0, 1, -1},
      '{1, 0, 16'h0, 0, 16'h0, 0, 0, -1, 0, 0, 0},
      '{0, K+1, 16'h5A5A, 1, 16'h0, 0, 1, 0, 0, 1, -1},
      '{0, 8193, 16'h0, 0, 16'h0, 0, 1, 0, 0, 1, 0},
      '{0, SCREEN_BASE+1, 16'h0, 0, 16'h0, 0, 0, 0, 0, 1, -1},
      '{0, 32767, 16'h0, 0, 16'h0, 0, 0, 0, 0, 1, -1},
      '{0, K, 16'h7777, 1, 16'h0, 0, 0, 0, 0, 1, -1}
    };

    reset = 1'b1; addressM = '0; outM = '0; writeM = 1'b0;
    key_data = '0; key_valid = 1'b0; scan_addr = '0;
    scan_m = 16'h0; scan_k = 0; bad_m = 0;
    @(posedge clk);
    model_edge();
    #1;

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.rst, v.addr, v.wdat, v.wr, v.key, v.kvld, v.saddr);
      if (v.ei >= 0) check($sformatf("vec%0d_inM", i), inM, v.ei);
      edge_step();
      check($sformatf("vec%0d_count", i), kbd_count, v.ecnt);
      check($sformatf("vec%0d_key_ready", i), key_ready, v.ecnt != KBD_DEPTH);
      check($sformatf("vec%0d_bad", i), bad_access, v.ebad);
      if (v.es >= 0) check($sformatf("vec%0d_scan", i), scan_data, v.es);
    end

    // Screen scan read-before-write on the same word.
    drive(0, SCREEN_BASE+7, 16'hAAAA, 1, 16'h0, 0, 0); edge_step();
    drive(0, SCREEN_BASE+7, 16'h5555, 1, 16'h0, 0, 7); edge_step();
    check("rbw_old", scan_data, 16'hAAAA);
    drive(0, SCREEN_BASE+7, 16'h0, 0, 16'h0, 0, 7);
    check("rbw_inM", inM, 16'h5555);
    edge_step();
    check("rbw_new", scan_data, 16'h5555);

    // Reset mid-stream with a write and a push pending on the reset edge.
    drive(0, 0, 16'h0777, 1, 16'h0, 0, 7); edge_step();
    drive(0, 0, 16'h0, 0, 16'h61, 1, 7); edge_step();
    drive(0, 0, 16'h0, 0, 16'h62, 1, 7); edge_step();
    drive(0, 0, 16'h0, 0, 16'h63, 1, 7); edge_step();
    check("mid_count_pre", kbd_count, 3);
    drive(1, 0, 16'hDEAD, 1, 16'h64, 1, 7); edge_step();
    check("mid_count", kbd_count, 0);
    check("mid_ready", key_ready, 1);
    check("mid_scan", scan_data, 0);
    check("mid_bad", bad_access, 0);
    drive(0, K, 16'h0, 0, 16'h0, 0, 7);
    check("mid_kbd_inM", inM, 0);
    drive(0, 0, 16'h0, 0, 16'h0, 0, 7);
    check("mid_ram0", inM, 16'h0777);
    edge_step();
    check("mid_count_post", kbd_count, 0);

    // Random traffic against the model, concentrated on region boundaries.
    for (int n = 0; n < 800; n++) begin
      case ($urandom_range(0, 5))
        0: a = $urandom_range(0, 7);
        1: a = RAM_WORDS - 1 - $urandom_range(0, 7);
        2: a = SCREEN_BASE + $urandom_range(0, 7);
        3: a = SCREEN_BASE + SCREEN_WORDS - 1 - $urandom_range(0, 7);
        4: a = KBD_ADDR;
        default: a = ($urandom_range(0, 3) == 0) ? 32767 - $urandom_range(0, 3) : KBD_ADDR;
      endcase
      sa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : SCREEN_WORDS - 1 - $urandom_range(0, 7);
      drive($urandom_range(0, 63) == 0, a, 16'($urandom), $urandom_range(0, 1) == 1,
            16'($urandom), $urandom_range(0, 2) != 0, sa);
      if (model_read(a, mv)) check("rand_inM", inM, mv);
      edge_step();
      check("rand_count", kbd_count, kq.size());
      check("rand_key_ready", key_ready, kq.size() != KBD_DEPTH);
      check("rand_bad", bad_access, bad_m);
      if (scan_k) check("rand_scan", scan_data, scan_m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
